// File: rtl/mcu_if_pkg.sv
// Shared definitions for the MCU command link: word width, parser header
// words and the receiver FSM state encoding.
package mcu_if_pkg;

    localparam int MCU_WORD_W = 16;

    localparam logic [MCU_WORD_W-1:0] HDR_WORD_A = 16'h9B5D;
    localparam logic [MCU_WORD_W-1:0] HDR_WORD_B = 16'hB79E;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ABORT = 2'd2
    } rx_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for one asynchronous pin, plus a delay flop so the
// synchronised level can be turned into single-cycle rise/fall strobes.
module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk_in,
    input  logic rst,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~dly_q;
    assign fall_o = ~sync_o & dly_q;

endmodule

// File: rtl/mcu_spi_word_rx.sv
// SPI mode-0 word receiver for the MCU command parser, oversampled in clk_in.
// Define MCU_RX_TIMEOUT_EN to abort partial words after TIMEOUT_CYC idle cycles.
module mcu_spi_word_rx
    import mcu_if_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int WORD_W      = MCU_WORD_W,
    parameter int CNT_W       = 5,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic [WORD_W-1:0] ok1,
    output logic              data_valid,
    output logic              frame_active,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              err_partial,
    output logic [7:0]        err_cnt
);

    localparam int BC_W = $clog2(WORD_W);
    localparam int SE_W = $clog2(SYNC_STAGES + 2);
    localparam logic [SE_W-1:0] SETTLE_END = SE_W'(SYNC_STAGES + 1);

    logic sclk_rise, cs_s, cs_rise, cs_fall, mosi_s;
    logic [SYNC_STAGES-1:0] mosi_q;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk_in(clk_in), .rst(rst), .d_i(spi_sclk),
        .sync_o(), .rise_o(sclk_rise), .fall_o()
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk_in(clk_in), .rst(rst), .d_i(spi_cs_n),
        .sync_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) mosi_q <= '0;
        else     mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
    end
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    // The cs_n chain resets high, so a pin held low through reset would look
    // like a falling edge. Only arm frame start once cs_n is seen high after
    // the chain has flushed.
    logic [SE_W-1:0] settle_q;
    logic            armed_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            settle_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            if (settle_q != SETTLE_END) settle_q <= settle_q + 1'b1;
            if (settle_q == SETTLE_END && cs_s) armed_q <= 1'b1;
        end
    end

    rx_state_e         state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d, ok1_q, ok1_d, shifted;
    logic [BC_W-1:0]   bit_q, bit_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic [7:0]        ecnt_q, ecnt_d;
    logic              done_q, done_d, dv_q;

`ifdef MCU_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_q, to_d;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) to_q <= '0;
        else     to_q <= to_d;
    end
`endif

    assign shifted = {shift_q[WORD_W-2:0], mosi_s};

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        ok1_d   = ok1_q;
        wcnt_d  = wcnt_q;
        ecnt_d  = ecnt_q;
        done_d  = 1'b0;
`ifdef MCU_RX_TIMEOUT_EN
        to_d    = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                shift_d = '0;
                bit_d   = '0;
                if (cs_fall && armed_q) begin
                    state_d = ST_SHIFT;
                    wcnt_d  = '0;
                end
            end
            ST_SHIFT: begin
                // cs_n deassertion takes priority over a coincident SCLK rise
                if (cs_rise) begin
                    state_d = (bit_q == '0) ? ST_IDLE : ST_ABORT;
                end else if (sclk_rise) begin
                    shift_d = shifted;
                    if (bit_q == BC_W'(WORD_W - 1)) begin
                        ok1_d  = shifted;
                        done_d = 1'b1;
                        bit_d  = '0;
                        if (wcnt_q != {CNT_W{1'b1}}) wcnt_d = wcnt_q + 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
`ifdef MCU_RX_TIMEOUT_EN
                else if (bit_q != '0) begin
                    if (to_q == TO_W'(TIMEOUT_CYC - 1)) state_d = ST_ABORT;
                    else                                to_d    = to_q + 1'b1;
                end
`endif
            end
            ST_ABORT: begin
                shift_d = '0;
                bit_d   = '0;
                if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 1'b1;
                state_d = cs_s ? ST_IDLE : ST_SHIFT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            ok1_q   <= '0;
            wcnt_q  <= '0;
            ecnt_q  <= '0;
            done_q  <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            ok1_q   <= ok1_d;
            wcnt_q  <= wcnt_d;
            ecnt_q  <= ecnt_d;
            done_q  <= done_d;
            dv_q    <= done_q;
        end
    end

    assign ok1          = ok1_q;
    assign data_valid   = dv_q;
    assign frame_active = (state_q != ST_IDLE) & ~cs_s;
    assign word_cnt     = wcnt_q;
    assign err_partial  = (state_q == ST_ABORT);
    assign err_cnt      = ecnt_q;

endmodule

// File: tb/tb_mcu_spi_word_rx.sv
// Directed/random bench for mcu_spi_word_rx: frames are built as bit queues and
// the expected words, counts and errors are derived from them arithmetically.
module tb_mcu_spi_word_rx;

    localparam int SS = 2;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic [15:0] ok1;
    logic        data_valid, frame_active, err_partial;
    logic [4:0]  word_cnt;
    logic [7:0]  err_cnt;

    always #5 clk_in = ~clk_in;

    mcu_spi_word_rx #(
        .SYNC_STAGES(SS), .WORD_W(16), .CNT_W(5), .TIMEOUT_CYC(64)
    ) dut (
        .clk_in(clk_in), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .ok1(ok1), .data_valid(data_valid),
        .frame_active(frame_active), .word_cnt(word_cnt),
        .err_partial(err_partial), .err_cnt(err_cnt)
    );

    int ncmp = 0;
    int nerr = 0;

    logic [15:0] obs_w[$];
    logic [4:0]  obs_c[$];
    int          errp_seen = 0;

    always @(negedge clk_in) begin
        if (!rst) begin
            if (data_valid) begin
                obs_w.push_back(ok1);
                obs_c.push_back(word_cnt);
            end
            if (err_partial) errp_seen++;
        end
    end

    // reference model state
    bit          tx_q[$];
    logic [15:0] exp_w[$];
    logic [4:0]  exp_c[$];
    logic [15:0] exp_ok1 = '0;
    int          exp_err = 0;
    int          exp_wc  = 0;
    bit          exp_part;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) tx_q.push_back(w[i]);
    endtask

    task automatic model_frame();
        int acc = 0;
        int nb = 0;
        int k = 0;
        exp_w.delete();
        exp_c.delete();
        exp_wc = 0;
        foreach (tx_q[i]) begin
            acc = (acc * 2 + int'(tx_q[i])) % 65536;
            nb++;
            if (nb == 16) begin
                k++;
                exp_wc = (k > 31) ? 31 : k;
                exp_w.push_back(16'(acc));
                exp_c.push_back(5'(exp_wc));
                exp_ok1 = 16'(acc);
                acc = 0;
                nb = 0;
            end
        end
        exp_part = (nb != 0);
        if (exp_part && exp_err < 255) exp_err++;
    endtask

    task automatic send_bit(input bit b);
        @(negedge clk_in) spi_mosi = b;
        repeat (4) @(negedge clk_in);
        spi_sclk = 1'b1;
        repeat (4) @(negedge clk_in);
        spi_sclk = 1'b0;
    endtask

    task automatic cs_low();
        @(negedge clk_in) spi_cs_n = 1'b0;
        repeat (6) @(negedge clk_in);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk_in);
        spi_cs_n = 1'b1;
        repeat (10) @(negedge clk_in);
    endtask

    task automatic check_frame(input string tag, input int e0);
        int n;
        chk({tag, "_nwords"}, obs_w.size(), exp_w.size());
        n = (obs_w.size() < exp_w.size()) ? obs_w.size() : exp_w.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_word"}, obs_w[i], exp_w[i]);
            chk({tag, "_wcnt_at_valid"}, obs_c[i], exp_c[i]);
        end
        chk({tag, "_ok1"}, ok1, exp_ok1);
        chk({tag, "_word_cnt"}, word_cnt, exp_wc);
        chk({tag, "_err_cnt"}, err_cnt, exp_err);
        chk({tag, "_err_pulses"}, errp_seen - e0, exp_part ? 1 : 0);
        chk({tag, "_frame_inactive"}, frame_active, 1'b0);
    endtask

    task automatic run_frame(input string tag);
        int e0;
        model_frame();
        e0 = errp_seen;
        obs_w.delete();
        obs_c.delete();
        cs_low();
        chk({tag, "_frame_active"}, frame_active, 1'b1);
        foreach (tx_q[i]) send_bit(tx_q[i]);
        cs_high();
        check_frame(tag, e0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ok1"}, ok1, 16'h0);
        chk({tag, "_dv"}, data_valid, 1'b0);
        chk({tag, "_fa"}, frame_active, 1'b0);
        chk({tag, "_wcnt"}, word_cnt, 5'h0);
        chk({tag, "_errp"}, err_partial, 1'b0);
        chk({tag, "_errcnt"}, err_cnt, 8'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, e0;
        logic [15:0] w;

        repeat (3) @(negedge clk_in);
        check_reset("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk_in);

        tx_q.delete();
        push_word(16'h9B5D, 16);
        push_word(16'h1234, 16);
        run_frame("two_words");

        tx_q.delete();
        push_word(16'h007F, 7);
        run_frame("partial7");

        // latency from the final SCLK pin rise to data_valid
        tx_q.delete();
        push_word(16'hC3A5, 16);
        model_frame();
        e0 = errp_seen;
        obs_w.delete();
        obs_c.delete();
        cs_low();
        for (int i = 0; i < 15; i++) send_bit(tx_q[i]);
        @(negedge clk_in) spi_mosi = tx_q[15];
        repeat (4) @(negedge clk_in);
        spi_sclk = 1'b1;
        n = 0;
        while (n < 20) begin
            @(posedge clk_in);
            #1;
            n++;
            if (data_valid) break;
        end
        chk("latency", n, SS + 2);
        repeat (3) @(negedge clk_in);
        spi_sclk = 1'b0;
        cs_high();
        check_frame("latency_frame", e0);

        tx_q.delete();
        for (int i = 0; i < 40; i++) push_word(16'($urandom), 16);
        run_frame("sat40");

        tx_q.delete();
        push_word(16'($urandom), 16);
        run_frame("after_sat");

        // reset in the middle of a word with cs_n held low
        tx_q.delete();
        push_word(16'h5A5A, 9);
        cs_low();
        foreach (tx_q[i]) send_bit(tx_q[i]);
        @(negedge clk_in) rst = 1'b1;
        repeat (2) @(negedge clk_in);
        check_reset("midword_rst");
        rst = 1'b0;
        exp_ok1 = '0;
        exp_err = 0;
        exp_wc  = 0;
        obs_w.delete();
        obs_c.delete();
        repeat (8) @(negedge clk_in);
        w = 16'($urandom);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
        chk("post_rst_ignored_words", obs_w.size(), 0);
        chk("post_rst_idle", frame_active, 1'b0);
        chk("post_rst_ok1", ok1, 16'h0);
        spi_cs_n = 1'b1;
        repeat (10) @(negedge clk_in);
        tx_q.delete();
        push_word(16'hB79E, 16);
        run_frame("post_rst_frame");

        for (int f = 0; f < 6; f++) begin
            tx_q.delete();
            n = $urandom_range(1, 50);
            for (int i = 0; i < n; i++) tx_q.push_back(bit'($urandom_range(0, 1)));
            run_frame("rand");
        end

`ifdef MCU_RX_TIMEOUT_EN
        e0 = errp_seen;
        obs_w.delete();
        obs_c.delete();
        cs_low();
        w = 16'h1F1F;
        for (int i = 15; i > 10; i--) send_bit(w[i]);
        repeat (100) @(negedge clk_in);
        chk("timeout_err_pulse", errp_seen - e0, 1);
        if (exp_err < 255) exp_err++;
        w = 16'hABCD;
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
        cs_high();
        chk("timeout_nwords", obs_w.size(), 1);
        chk("timeout_ok1", ok1, 16'hABCD);
        chk("timeout_err_cnt", err_cnt, exp_err);
`endif

        for (int f = 0; f < 299; f++) begin
            tx_q.delete();
            push_word(16'($urandom), 3);
            model_frame();
            cs_low();
            foreach (tx_q[i]) send_bit(tx_q[i]);
            cs_high();
        end
        tx_q.delete();
        push_word(16'h0005, 3);
        run_frame("err_sat");
        chk("err_cnt_saturated", err_cnt, 8'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
